// File: rtl/cred_enroll_pkg.sv
// Shared widths, state encodings and state-to-output decode for the credential enrollment writer.
// The access controller compares against the same USER/PASS widths.
package cred_enroll_pkg;

   localparam int USER_W_DEF = 16;
   localparam int PASS_W_DEF = 20;
   localparam int ADDR_W_DEF = 3;
   localparam int USER_NIBS  = USER_W_DEF / 4;
   localparam int PASS_NIBS  = PASS_W_DEF / 4;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_USER_IN = 3'd1,
      S_SCAN    = 3'd2,
      S_PASS_IN = 3'd3,
      S_WRITE   = 3'd4,
      S_DONE    = 3'd5,
      S_ERR     = 3'd6
   } state_t;

   typedef struct packed {
      logic busy;
      logic dup_err;
      logic led_r;
      logic led_g;
      logic wr_en;
   } flags_t;

   function automatic flags_t state_flags(input state_t s);
      flags_t f;
      f = '0;
      case (s)
         S_USER_IN: begin f.busy = 1'b1; f.led_r = 1'b1; end
         S_SCAN:    f.busy = 1'b1;
         S_PASS_IN: begin f.busy = 1'b1; f.led_r = 1'b1; end
         S_WRITE:   begin f.busy = 1'b1; f.wr_en = 1'b1; end
         S_DONE:    f.led_g = 1'b1;
         S_ERR:     begin f.dup_err = 1'b1; f.led_r = 1'b1; end
         default:   f.led_r = 1'b1;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/cred_enroll_nib_shift.sv
// Nibble-wide shift register (MSB first) with a count of accepted nibbles.
// Clear wins over shift so an abort in the same cycle as a keypress leaves it empty.
module nib_shift #(
   parameter int W = 16
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_clr,
   input  logic                           i_shift,
   input  logic [3:0]                     i_nib,
   output logic [W-1:0]                   o_val,
   output logic [$clog2(W/4+1)-1:0]       o_cnt
);

   localparam int CW = $clog2(W/4+1);

   logic [W-1:0]  r_val;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst || i_clr) begin
         r_val <= '0;
         r_cnt <= '0;
      end else if (i_shift) begin
         r_val <= {r_val[W-5:0], i_nib};
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_val = r_val;
   assign o_cnt = r_cnt;

endmodule

// File: rtl/cred_enroll.sv
// Credential enrollment writer: collects a user ID and password nibble by nibble,
// rejects duplicate IDs by scanning the user RAM, then writes the pair to the next free slot.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for first user nibble (ignored while table full)
//   USER_IN | collecting user ID nibbles
//   SCAN    | reading entries 0..count-1, comparing one cycle behind
//   PASS_IN | collecting password nibbles
//   WRITE   | single-cycle write strobe to both RAMs
//   DONE    | enrollment accepted, waiting for acknowledge
//   ERR     | duplicate ID found, waiting for acknowledge
module cred_enroll
   import cred_enroll_pkg::*;
#(
   parameter int USER_W = USER_W_DEF,
   parameter int PASS_W = PASS_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_b_en,
   input  logic              i_b_clr,
   input  logic [3:0]        i_swt_en,
   input  logic [USER_W-1:0] i_rd_data,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [USER_W-1:0] o_wr_user,
   output logic [PASS_W-1:0] o_wr_pass,
   output logic [ADDR_W:0]   o_count,
   output logic              o_full,
   output logic              o_busy,
   output logic              o_dup_err,
   output logic              o_led_r,
   output logic              o_led_g
);

   localparam int UN  = USER_W / 4;
   localparam int PN  = PASS_W / 4;
   localparam int UCW = $clog2(UN + 1);
   localparam int PCW = $clog2(PN + 1);
   localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(2**ADDR_W);

   state_t            r_state;
   state_t            w_state_nxt;
   flags_t            r_flags;
   logic [ADDR_W:0]   r_count;
   logic [ADDR_W:0]   r_scan_idx;
   logic              r_cmp_vld;

   logic [USER_W-1:0] w_user;
   logic [PASS_W-1:0] w_pass;
   logic [UCW-1:0]    w_user_cnt;
   logic [PCW-1:0]    w_pass_cnt;
   logic              w_en;
   logic              w_full;
   logic              w_user_shift;
   logic              w_pass_shift;
   logic              w_clr;
   logic              w_match;

   assign w_en         = i_b_en & ~i_b_clr;
   assign w_full       = (r_count == CAP);
   assign w_user_shift = w_en & (((r_state == S_IDLE) & ~w_full) | (r_state == S_USER_IN));
   assign w_pass_shift = w_en & (r_state == S_PASS_IN);
   // acknowledging DONE/ERR also empties the registers so the next entry starts clean
   assign w_clr        = i_b_clr | (i_b_en & ((r_state == S_DONE) | (r_state == S_ERR)));
   assign w_match      = r_cmp_vld & (i_rd_data == w_user);

   nib_shift #(.W(USER_W)) u_user (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (w_clr),
      .i_shift (w_user_shift),
      .i_nib   (i_swt_en),
      .o_val   (w_user),
      .o_cnt   (w_user_cnt)
   );

   nib_shift #(.W(PASS_W)) u_pass (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (w_clr),
      .i_shift (w_pass_shift),
      .i_nib   (i_swt_en),
      .o_val   (w_pass),
      .o_cnt   (w_pass_cnt)
   );

   always_comb begin
      w_state_nxt = r_state;
      if (i_b_clr) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    if (w_user_shift) w_state_nxt = S_USER_IN;
            S_USER_IN: if (i_b_en && w_user_cnt == UCW'(UN - 1))
                          w_state_nxt = (r_count != '0) ? S_SCAN : S_PASS_IN;
            S_SCAN:    if (w_match) w_state_nxt = S_ERR;
                       else if (r_scan_idx == r_count) w_state_nxt = S_PASS_IN;
            S_PASS_IN: if (i_b_en && w_pass_cnt == PCW'(PN - 1)) w_state_nxt = S_WRITE;
            S_WRITE:   w_state_nxt = S_DONE;
            S_DONE:    if (i_b_en) w_state_nxt = S_IDLE;
            S_ERR:     if (i_b_en) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state    <= S_IDLE;
         r_flags    <= state_flags(S_IDLE);
         r_count    <= '0;
         r_scan_idx <= '0;
         r_cmp_vld  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_flags <= state_flags(w_state_nxt);
         if (r_state == S_WRITE && !w_full)
            r_count <= r_count + (ADDR_W+1)'(1);
         // the address issued this cycle is compared next cycle, so cmp_vld trails the index
         if (r_state == S_SCAN && w_state_nxt == S_SCAN) begin
            r_scan_idx <= r_scan_idx + (ADDR_W+1)'(1);
            r_cmp_vld  <= 1'b1;
         end else begin
            r_scan_idx <= '0;
            r_cmp_vld  <= 1'b0;
         end
      end
   end

   assign o_rd_addr = r_scan_idx[ADDR_W-1:0];
   assign o_wr_en   = r_flags.wr_en;
   assign o_wr_addr = r_count[ADDR_W-1:0];
   assign o_wr_user = w_user;
   assign o_wr_pass = w_pass;
   assign o_count   = r_count;
   assign o_full    = w_full;
   assign o_busy    = r_flags.busy;
   assign o_dup_err = r_flags.dup_err;
   assign o_led_r   = r_flags.led_r;
   assign o_led_g   = r_flags.led_g;

endmodule

// File: tb/tb_cred_enroll.sv
// Directed bench for cred_enroll with a registered-address user RAM model.
module tb_cred_enroll;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        b_en = 1'b0;
   logic        b_clr = 1'b0;
   logic [3:0]  swt = 4'h0;
   logic [15:0] rd_data;
   logic [2:0]  rd_addr;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_user;
   logic [19:0] wr_pass;
   logic [3:0]  count;
   logic        full, busy, dup_err, led_r, led_g;

   logic [15:0] mem [8];
   int          wr_cnt = 0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   cred_enroll dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_b_en    (b_en),
      .i_b_clr   (b_clr),
      .i_swt_en  (swt),
      .i_rd_data (rd_data),
      .o_rd_addr (rd_addr),
      .o_wr_en   (wr_en),
      .o_wr_addr (wr_addr),
      .o_wr_user (wr_user),
      .o_wr_pass (wr_pass),
      .o_count   (count),
      .o_full    (full),
      .o_busy    (busy),
      .o_dup_err (dup_err),
      .o_led_r   (led_r),
      .o_led_g   (led_g)
   );

   always @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_user;
         wr_cnt <= wr_cnt + 1;
      end
      rd_data <= mem[rd_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] n);
      @(negedge clk);
      b_en = 1'b1;
      swt  = n;
      @(negedge clk);
      b_en = 1'b0;
   endtask

   task automatic wait_scan();
      int n = 0;
      while (busy && !led_r && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("scan_bound", 32'(n < 20), 32'd1);
   endtask

   task automatic enter_user(input logic [15:0] u);
      for (int i = 3; i >= 0; i--) press(u[4*i +: 4]);
      wait_scan();
      chk("in_pass_state", {30'd0, busy, led_r}, 32'd3);
   endtask

   task automatic enter_pass(input logic [19:0] p);
      for (int i = 4; i >= 0; i--) press(p[4*i +: 4]);
   endtask

   task automatic check_write(input logic [2:0] a, input logic [15:0] u,
                              input logic [19:0] p, input logic [3:0] c);
      chk("wr_en", 32'(wr_en), 32'd1);
      chk("wr_addr", 32'(wr_addr), 32'(a));
      chk("wr_user", 32'(wr_user), 32'(u));
      chk("wr_pass", 32'(wr_pass), 32'(p));
      @(negedge clk);
      chk("done_led_g", 32'(led_g), 32'd1);
      chk("done_wr_en", 32'(wr_en), 32'd0);
      chk("done_count", 32'(count), 32'(c));
      press(4'h0);
      chk("ack_idle", {30'd0, led_r, led_g}, 32'd2);
   endtask

   task automatic enroll(input logic [15:0] u, input logic [19:0] p, input logic [2:0] a);
      enter_user(u);
      enter_pass(p);
      check_write(a, u, p, 4'(a) + 4'd1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_flags", {27'd0, busy, dup_err, led_r, led_g, wr_en}, 32'b00100);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_rd_addr", 32'(rd_addr), 32'd0);
      rst = 1'b1;

      // 1: empty table, no scan
      press(4'hA); press(4'hB); press(4'hC); press(4'hD);
      chk("t1_no_scan", {30'd0, busy, led_r}, 32'd3);
      enter_pass(20'h12345);
      check_write(3'd0, 16'hABCD, 20'h12345, 4'd1);
      chk("t1_wr_cnt", 32'(wr_cnt), 32'd1);

      enroll(16'h1234, 20'h00001, 3'd1);

      // 2: duplicate ID
      press(4'h1); press(4'h2); press(4'h3); press(4'h4);
      chk("t2_rd0", 32'(rd_addr), 32'd0);
      @(negedge clk);
      chk("t2_rd1", 32'(rd_addr), 32'd1);
      chk("t2_busy", 32'(busy), 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk("t2_dup_err", 32'(dup_err), 32'd1);
      chk("t2_err_flags", {30'd0, busy, led_r}, 32'd1);
      press(4'h7);
      chk("t2_ack", {30'd0, dup_err, led_r}, 32'd1);
      chk("t2_count", 32'(count), 32'd2);
      chk("t2_wr_cnt", 32'(wr_cnt), 32'd2);

      // 3: abort with b_clr coinciding with b_en
      enter_user(16'h5678);
      press(4'h1); press(4'h2);
      @(negedge clk);
      b_en = 1'b1; b_clr = 1'b1; swt = 4'h3;
      @(negedge clk);
      b_en = 1'b0; b_clr = 1'b0;
      chk("t3_idle", {30'd0, busy, led_r}, 32'd1);
      chk("t3_wr_cnt", 32'(wr_cnt), 32'd2);
      enroll(16'hC033, 20'h00002, 3'd2);

      // 6: b_en held across scan cycles
      press(4'h7); press(4'h7); press(4'h7);
      @(negedge clk);
      b_en = 1'b1; swt = 4'h7;
      @(negedge clk);
      swt = 4'hF;
      for (int i = 0; i < 20 && busy && !led_r; i++) @(negedge clk);
      b_en = 1'b0;
      chk("t6_pass_state", {30'd0, busy, led_r}, 32'd3);
      enter_pass(20'h98765);
      check_write(3'd3, 16'h7777, 20'h98765, 4'd4);

      // 4: fill the table
      enroll(16'h4444, 20'hAAAAA, 3'd4);
      enroll(16'h5555, 20'hBBBBB, 3'd5);
      enroll(16'h6666, 20'hCCCCC, 3'd6);
      enter_user(16'h8888);
      enter_pass(20'hDDDDD);
      check_write(3'd7, 16'h8888, 20'hDDDDD, 4'd8);
      chk("t4_full", 32'(full), 32'd1);
      press(4'h1);
      chk("t4_ignored", {30'd0, busy, led_r}, 32'd1);
      chk("t4_count", 32'(count), 32'd8);
      chk("t4_wr_cnt", 32'(wr_cnt), 32'd8);

      // 5: reset in the middle of password entry
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      enter_user(16'h1111);
      press(4'h0); press(4'h0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      chk("t5_count", 32'(count), 32'd0);
      chk("t5_flags", {27'd0, busy, dup_err, led_r, led_g, wr_en}, 32'b00100);
      chk("t5_full", 32'(full), 32'd0);
      rst = 1'b1;
      enroll(16'h2222, 20'h0000A, 3'd0);
      chk("t5_wr_cnt", 32'(wr_cnt), 32'd9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
